// File: rtl/gray_code_pkg.sv
// -----------------------------------------------------------------------------
// gray_code_pkg
// Shared Gray-code helpers for both sides of the asynchronous FIFO.
//   bin_to_gray : binary -> reflected Gray code
//   gray_to_bin : reflected Gray code -> binary
// Both functions work on a GRAY_MAX_WIDTH-bit word. Callers zero-extend their
// narrower value in and size-cast the result back to their own width. Zero
// upper bits stay zero through either conversion, so the result is exact for
// any width up to GRAY_MAX_WIDTH.
// -----------------------------------------------------------------------------
package gray_code_pkg;

   localparam int GRAY_MAX_WIDTH = 32;

   typedef logic [GRAY_MAX_WIDTH-1:0] gray_word_t;

   function automatic gray_word_t bin_to_gray(input gray_word_t bin);
      return bin ^ (bin >> 1);
   endfunction

   // b[MSB] = g[MSB], b[i] = b[i+1] ^ g[i]
   function automatic gray_word_t gray_to_bin(input gray_word_t gray);
      gray_word_t bin;
      bin[GRAY_MAX_WIDTH-1] = gray[GRAY_MAX_WIDTH-1];
      for (int i = GRAY_MAX_WIDTH - 2; i >= 0; i--) begin
         bin[i] = bin[i+1] ^ gray[i];
      end
      return bin;
   endfunction

endpackage

// File: rtl/gray_code_decode.sv
// -----------------------------------------------------------------------------
// gray_code_decode
// Combinational Gray-to-binary converter, the counterpart of the Gray encoder.
//   WIDTH       : code width in bits (at most gray_code_pkg::GRAY_MAX_WIDTH)
//   gray_code   : input, Gray-coded value
//   binary_code : output, binary equivalent
// -----------------------------------------------------------------------------
module gray_code_decode #(
   parameter int WIDTH = 5
) (
   input  logic [WIDTH-1:0] gray_code,
   output logic [WIDTH-1:0] binary_code
);
   import gray_code_pkg::*;

   assign binary_code = WIDTH'(gray_to_bin(GRAY_MAX_WIDTH'(gray_code)));

endmodule

// File: rtl/gray_ptr_read_ctrl.sv
// -----------------------------------------------------------------------------
// gray_ptr_read_ctrl
// Read-side pointer controller of an asynchronous FIFO.
//   clock          : read-domain clock, all state updates on its rising edge
//   reset          : asynchronous, active-high
//   write_ptr_gray : Gray write pointer from the write domain (asynchronous)
//   read_enable    : read request for the current cycle
//   read_addr      : RAM read address (low ADDR_WIDTH bits of binary read ptr)
//   read_ptr_gray  : registered Gray read pointer, for the write domain
//   empty          : registered FIFO-empty flag
//   level          : registered occupancy, 0 .. 2**ADDR_WIDTH
//   underflow      : one-cycle pulse after a rejected read
//
// Read handshake: read_enable is a request and ~empty is the grant. A read is
// taken on a rising edge where read_enable=1 and empty=0. A request while
// empty=1 is dropped: the pointer holds and underflow pulses for one cycle.
//
// Pointers are ADDR_WIDTH+1 bits wide. The extra MSB separates full
// (level=2**ADDR_WIDTH) from empty after wrap-around. empty and level are
// computed from the next read pointer, so the edge that takes the last entry
// also raises empty.
// -----------------------------------------------------------------------------
module gray_ptr_read_ctrl #(
   parameter int ADDR_WIDTH  = 4,
   parameter int SYNC_STAGES = 2    // minimum 2
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [ADDR_WIDTH:0]   write_ptr_gray,
   input  logic                  read_enable,
   output logic [ADDR_WIDTH-1:0] read_addr,
   output logic [ADDR_WIDTH:0]   read_ptr_gray,
   output logic                  empty,
   output logic [ADDR_WIDTH:0]   level,
   output logic                  underflow
);
   import gray_code_pkg::*;

   localparam int PTR_W = ADDR_WIDTH + 1;

   logic [PTR_W-1:0] sync_q [SYNC_STAGES];
   logic [PTR_W-1:0] wgray_sync;
   logic [PTR_W-1:0] wbin_sync;
   logic [PTR_W-1:0] rbin_q;
   logic [PTR_W-1:0] rbin_next;
   logic [PTR_W-1:0] rgray_next;
   logic             accept;

   // Write-pointer synchronizer. Only the last stage feeds any logic.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            sync_q[i] <= '0;
         end
      end else begin
         sync_q[0] <= write_ptr_gray;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
      end
   end

   assign wgray_sync = sync_q[SYNC_STAGES-1];

   gray_code_decode #(
      .WIDTH (PTR_W)
   ) u_wsync_decode (
      .gray_code   (wgray_sync),
      .binary_code (wbin_sync)
   );

   assign accept     = read_enable && !empty;
   assign rbin_next  = rbin_q + PTR_W'(accept);
   assign rgray_next = PTR_W'(bin_to_gray(GRAY_MAX_WIDTH'(rbin_next)));

   // Pointer and flags are all derived from rbin_next, so they move together.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rbin_q        <= '0;
         read_ptr_gray <= '0;
         empty         <= 1'b1;
         level         <= '0;
         underflow     <= 1'b0;
      end else begin
         rbin_q        <= rbin_next;
         read_ptr_gray <= rgray_next;
         empty         <= (rgray_next == wgray_sync);
         level         <= wbin_sync - rbin_next;   // modular, wraps cleanly
         underflow     <= read_enable && empty;
      end
   end

   assign read_addr = rbin_q[ADDR_WIDTH-1:0];

endmodule

// File: tb/tb_gray_ptr_read_ctrl.sv
// -----------------------------------------------------------------------------
// tb_gray_ptr_read_ctrl
// Self-checking bench for gray_ptr_read_ctrl (ADDR_WIDTH=4, SYNC_STAGES=2).
// A cycle model of the read side pushes the expected outputs
// {read_addr, read_ptr_gray, empty, level, underflow} into exp_q each time
// stimulus is driven. The scenario tasks pop the queue after the edge and
// compare against the DUT. Key points also get fixed hand-derived constants.
// -----------------------------------------------------------------------------
module tb_gray_ptr_read_ctrl;

   localparam int AW = 4;
   localparam int PW = AW + 1;

   logic          clock;
   logic          reset;
   logic [PW-1:0] write_ptr_gray;
   logic          read_enable;
   logic [AW-1:0] read_addr;
   logic [PW-1:0] read_ptr_gray;
   logic          empty;
   logic [PW-1:0] level;
   logic          underflow;

   int checks   = 0;
   int failures = 0;

   // packed expected/observed word: {addr[4], gray[5], empty, level[5], uf}
   logic [15:0] exp_q[$];

   // reference model state (binary pointers)
   logic [PW-1:0] m_s1, m_s2, m_rbin, m_level, cur_wbin;
   logic          m_empty, m_uf;

   gray_ptr_read_ctrl #(
      .ADDR_WIDTH  (AW),
      .SYNC_STAGES (2)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .write_ptr_gray (write_ptr_gray),
      .read_enable    (read_enable),
      .read_addr      (read_addr),
      .read_ptr_gray  (read_ptr_gray),
      .empty          (empty),
      .level          (level),
      .underflow      (underflow)
   );

   // ---------------- clock ----------------
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // ---------------- watchdog ----------------
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   // ---------------- model + driver ----------------
   task automatic model_reset();
      m_s1     = '0;
      m_s2     = '0;
      m_rbin   = '0;
      m_level  = '0;
      m_empty  = 1'b1;
      m_uf     = 1'b0;
      cur_wbin = '0;
   endtask

   // Drive one cycle of stimulus at the falling edge, advance the model to
   // the following rising edge, push its outputs, and return #1 after it.
   task automatic tick(input logic re, input logic [PW-1:0] wbin);
      logic          acc;
      logic [PW-1:0] rn;
      logic [PW-1:0] rg;
      @(negedge clock);
      read_enable    = re;
      write_ptr_gray = wbin ^ (wbin >> 1);
      cur_wbin       = wbin;
      acc     = re && !m_empty;
      rn      = m_rbin + {{(PW-1){1'b0}}, acc};
      m_uf    = re && m_empty;
      m_empty = (rn == m_s2);
      m_level = m_s2 - rn;
      m_rbin  = rn;
      m_s2    = m_s1;
      m_s1    = wbin;
      rg      = m_rbin ^ (m_rbin >> 1);
      exp_q.push_back({m_rbin[AW-1:0], rg, m_empty, m_level, m_uf});
      @(posedge clock);
      #1;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      logic [15:0] obs, exp_v;
      reset          = 1'b0;
      read_enable    = 1'b0;
      write_ptr_gray = '0;
      #1 reset = 1'b1;
      #2;
      obs = {read_addr, read_ptr_gray, empty, level, underflow};
      checks++;
      if (obs !== {4'd0, 5'd0, 1'b1, 5'd0, 1'b0}) begin
         failures++;
         $display("FAIL reset_async actual=%h required=%h", obs, {4'd0, 5'd0, 1'b1, 5'd0, 1'b0});
      end
      @(posedge clock);
      #1 reset = 1'b0;
      model_reset();
      tick(1'b0, 5'd0);
      obs   = {read_addr, read_ptr_gray, empty, level, underflow};
      exp_v = exp_q.pop_front();
      checks++;
      if (obs !== exp_v) begin
         failures++;
         $display("FAIL reset_idle actual=%h required=%h", obs, exp_v);
      end
   endtask

   // write pointer 0 -> 3: empty for two edges, then level=3 on the third
   task automatic test_sync_latency();
      logic [15:0] obs, exp_v;
      for (int i = 1; i <= 3; i++) begin
         tick(1'b0, 5'd3);
         obs   = {read_addr, read_ptr_gray, empty, level, underflow};
         exp_v = exp_q.pop_front();
         checks++;
         if (obs !== exp_v) begin
            failures++;
            $display("FAIL sync_latency edge=%0d actual=%h required=%h", i, obs, exp_v);
         end
         checks++;
         if (empty !== (i < 3)) begin
            failures++;
            $display("FAIL sync_empty edge=%0d actual=%b required=%b", i, empty, (i < 3));
         end
      end
      checks++;
      if (level !== 5'd3) begin
         failures++;
         $display("FAIL sync_level actual=%0d required=3", level);
      end
   endtask

   // three back-to-back reads drain the three entries with no bubble
   task automatic test_back_to_back();
      logic [15:0] obs, exp_v;
      logic [3:0]  exp_addr  [3] = '{4'd1, 4'd2, 4'd3};
      logic [4:0]  exp_gray  [3] = '{5'b00001, 5'b00011, 5'b00010};
      logic [4:0]  exp_level [3] = '{5'd2, 5'd1, 5'd0};
      logic        exp_empty [3] = '{1'b0, 1'b0, 1'b1};
      for (int i = 0; i < 3; i++) begin
         tick(1'b1, 5'd3);
         obs   = {read_addr, read_ptr_gray, empty, level, underflow};
         exp_v = exp_q.pop_front();
         checks++;
         if (obs !== exp_v) begin
            failures++;
            $display("FAIL b2b_model read=%0d actual=%h required=%h", i, obs, exp_v);
         end
         checks++;
         if (obs !== {exp_addr[i], exp_gray[i], exp_empty[i], exp_level[i], 1'b0}) begin
            failures++;
            $display("FAIL b2b_const read=%0d actual=%h required=%h", i, obs,
                     {exp_addr[i], exp_gray[i], exp_empty[i], exp_level[i], 1'b0});
         end
      end
   endtask

   // read while empty: pointer holds, underflow for exactly one cycle
   task automatic test_underflow();
      logic [15:0] obs, exp_v;
      logic        exp_uf [3] = '{1'b1, 1'b0, 1'b0};
      for (int i = 0; i < 3; i++) begin
         tick(i == 0, 5'd3);
         obs   = {read_addr, read_ptr_gray, empty, level, underflow};
         exp_v = exp_q.pop_front();
         checks++;
         if (obs !== exp_v) begin
            failures++;
            $display("FAIL underflow_model step=%0d actual=%h required=%h", i, obs, exp_v);
         end
         checks++;
         if ({read_addr, underflow} !== {4'd3, exp_uf[i]}) begin
            failures++;
            $display("FAIL underflow_pulse step=%0d actual addr=%0d uf=%b required addr=3 uf=%b",
                     i, read_addr, underflow, exp_uf[i]);
         end
      end
   endtask

   // reset asserted between edges with level=5 clears outputs at once
   task automatic test_mid_reset();
      logic [15:0] obs, exp_v;
      for (int i = 0; i < 3; i++) begin
         tick(1'b0, 5'd8);
         obs   = {read_addr, read_ptr_gray, empty, level, underflow};
         exp_v = exp_q.pop_front();
         checks++;
         if (obs !== exp_v) begin
            failures++;
            $display("FAIL midreset_fill step=%0d actual=%h required=%h", i, obs, exp_v);
         end
      end
      checks++;
      if (level !== 5'd5) begin
         failures++;
         $display("FAIL midreset_level_before actual=%0d required=5", level);
      end
      @(negedge clock);
      read_enable = 1'b1;
      #2;
      reset          = 1'b1;
      write_ptr_gray = '0;
      #1;
      obs = {read_addr, read_ptr_gray, empty, level, underflow};
      checks++;
      if (obs !== {4'd0, 5'd0, 1'b1, 5'd0, 1'b0}) begin
         failures++;
         $display("FAIL midreset_async actual=%h required=%h", obs, {4'd0, 5'd0, 1'b1, 5'd0, 1'b0});
      end
      read_enable = 1'b0;
      @(posedge clock);
      @(posedge clock);
      #1 reset = 1'b0;
      model_reset();
   endtask

   // fill to full (level 16), drain 16 reads, then run the pointer through
   // the 31 -> 0 wrap; also measures latency to the first accepted read
   task automatic test_wrap();
      logic [15:0] obs, exp_v;
      int          first_acc;
      first_acc = -1;
      for (int i = 1; i <= 19; i++) begin
         tick(1'b1, 5'd16);
         obs   = {read_addr, read_ptr_gray, empty, level, underflow};
         exp_v = exp_q.pop_front();
         checks++;
         if (obs !== exp_v) begin
            failures++;
            $display("FAIL wrap_fill edge=%0d actual=%h required=%h", i, obs, exp_v);
         end
         if (i == 3) begin
            checks++;
            if ({empty, level} !== {1'b0, 5'd16}) begin
               failures++;
               $display("FAIL wrap_full actual empty=%b level=%0d required empty=0 level=16", empty, level);
            end
         end
         if (first_acc < 0 && read_addr != 4'd0) first_acc = i;
      end
      checks++;
      if (first_acc != 4) begin
         failures++;
         $display("FAIL first_read_latency actual=%0d required=4", first_acc);
      end
      checks++;
      if ({read_addr, read_ptr_gray, empty} !== {4'd0, 5'b11000, 1'b1}) begin
         failures++;
         $display("FAIL wrap_drained actual addr=%0d gray=%b empty=%b required addr=0 gray=11000 empty=1",
                  read_addr, read_ptr_gray, empty);
      end
      // write to 28, drain 12; write to 4 (wrapped), drain 8 across 31->0
      for (int i = 0; i < 15; i++) begin
         tick(i >= 3, 5'd28);
         obs   = {read_addr, read_ptr_gray, empty, level, underflow};
         exp_v = exp_q.pop_front();
         checks++;
         if (obs !== exp_v) begin
            failures++;
            $display("FAIL wrap_to28 step=%0d actual=%h required=%h", i, obs, exp_v);
         end
      end
      for (int i = 0; i < 11; i++) begin
         tick(i >= 3, 5'd4);
         obs   = {read_addr, read_ptr_gray, empty, level, underflow};
         exp_v = exp_q.pop_front();
         checks++;
         if (obs !== exp_v) begin
            failures++;
            $display("FAIL wrap_to4 step=%0d actual=%h required=%h", i, obs, exp_v);
         end
         if (i == 2) begin
            checks++;
            if (level !== 5'd8) begin
               failures++;
               $display("FAIL wrap_level_across actual=%0d required=8", level);
            end
         end
      end
      checks++;
      if ({read_addr, read_ptr_gray, empty, level} !== {4'd4, 5'b00110, 1'b1, 5'd0}) begin
         failures++;
         $display("FAIL wrap_final actual addr=%0d gray=%b empty=%b level=%0d required 4 00110 1 0",
                  read_addr, read_ptr_gray, empty, level);
      end
   endtask

   // write advances by one on the same cycle a read is taken at level 4
   task automatic test_same_cycle();
      logic [15:0] obs, exp_v;
      for (int i = 0; i < 6; i++) begin
         if (i < 3) tick(1'b0, 5'd8);
         else       tick(i == 3, 5'd9);
         obs   = {read_addr, read_ptr_gray, empty, level, underflow};
         exp_v = exp_q.pop_front();
         checks++;
         if (obs !== exp_v) begin
            failures++;
            $display("FAIL same_cycle step=%0d actual=%h required=%h", i, obs, exp_v);
         end
         if (i == 2 || i == 5) begin
            checks++;
            if (level !== 5'd4) begin
               failures++;
               $display("FAIL same_cycle_level step=%0d actual=%0d required=4", i, level);
            end
         end
      end
   endtask

   // random reads and writes, occupancy never above 2**AW
   task automatic test_random();
      logic [15:0]   obs, exp_v;
      logic [PW-1:0] w, occ;
      w = cur_wbin;
      for (int i = 0; i < 200; i++) begin
         occ = w - m_rbin;
         if (occ < 5'd16 && $urandom_range(0, 1) == 1) w = w + 5'd1;
         tick($urandom_range(0, 2) != 0, w);
         obs   = {read_addr, read_ptr_gray, empty, level, underflow};
         exp_v = exp_q.pop_front();
         checks++;
         if (obs !== exp_v) begin
            failures++;
            $display("FAIL random step=%0d actual=%h required=%h", i, obs, exp_v);
         end
      end
   endtask

   // ---------------- sequence + report ----------------
   initial begin
      model_reset();
      test_reset();
      test_sync_latency();
      test_back_to_back();
      test_underflow();
      test_mid_reset();
      test_wrap();
      test_same_cycle();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/gray_ptr_read_ctrl.md
GRAY_PTR_READ_CTRL -- requirements
Module: gray_ptr_read_ctrl

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 4, meaning FIFO address width (depth 2**ADDR_WIDTH, pointer width ADDR_WIDTH+1).
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2, minimum 2, meaning the number of synchronizer flops on the incoming write pointer.
REQ-003 The block SHALL have port clock, input, 1 bit: read-domain clock, all state on rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port write_ptr_gray, input, ADDR_WIDTH+1 bits: Gray-coded write pointer from the write clock domain, asynchronous to clock.
REQ-006 The block SHALL have port read_enable, input, 1 bit: read request for the current cycle.
REQ-007 The block SHALL have port read_addr, output, ADDR_WIDTH bits: RAM read address, equal to the low ADDR_WIDTH bits of the binary read pointer.
REQ-008 The block SHALL have port read_ptr_gray, output, ADDR_WIDTH+1 bits: registered Gray-coded read pointer, for synchronization into the write domain.
REQ-009 The block SHALL have port empty, output, 1 bit: registered FIFO-empty flag.
REQ-010 The block SHALL have port level, output, ADDR_WIDTH+1 bits: registered occupancy, 0..2**ADDR_WIDTH.
REQ-011 The block SHALL have port underflow, output, 1 bit: one-cycle pulse flagging a rejected read.

Function
REQ-012 write_ptr_gray SHALL pass through a SYNC_STAGES-deep flop chain; only the last stage (wgray_sync) SHALL be used by any other logic.
REQ-013 wgray_sync SHALL be decoded to binary wbin_sync: b[MSB]=g[MSB], b[i]=b[i+1]^g[i].
REQ-014 A read SHALL be accepted when read_enable=1 and empty=0; rbin_next = rbin+1 modulo 2**(ADDR_WIDTH+1), otherwise rbin_next = rbin.
REQ-015 read_ptr_gray SHALL be registered as rbin_next ^ (rbin_next>>1), updating on the same edge as rbin.
REQ-016 empty SHALL be registered as (gray(rbin_next) == wgray_sync).
REQ-017 level SHALL be registered as (wbin_sync - rbin_next) modulo 2**(ADDR_WIDTH+1).
REQ-018 A write-pointer change stable before edge N SHALL first be reflected in empty and level at edge N+SYNC_STAGES.
REQ-019 Reads SHALL be accepted back-to-back every cycle; empty SHALL assert on the edge that accepts the last available entry, with no bubble.
REQ-020 read_enable=1 while empty=1 SHALL leave rbin, read_addr and read_ptr_gray unchanged and SHALL set underflow=1 for exactly the next cycle.
REQ-021 If the write pointer advances in the same cycle a read is accepted, level SHALL reflect both changes, never going negative.
REQ-022 Pointer wrap from 2**(ADDR_WIDTH+1)-1 to 0 SHALL be seamless; the extra MSB SHALL distinguish full (level=2**ADDR_WIDTH) from empty.

Reset
REQ-023 Asserting reset SHALL immediately clear all synchronizer flops, rbin, read_addr, read_ptr_gray, level and underflow to 0, and set empty=1, without waiting for a clock edge.
REQ-024 Reset asserted mid-operation SHALL discard any in-flight read; the first read after release SHALL be accepted no earlier than SYNC_STAGES+1 edges after write_ptr_gray becomes nonzero.

Structure
REQ-025 A shared package gray_code_pkg SHALL hold the binary-to-Gray and Gray-to-binary functions, parameterized on width and reused by the write-side controller.
REQ-026 The Gray-to-binary conversion SHALL be a combinational sub-module named gray_code_decode with ports gray_code and binary_code, the counterpart of the existing encoder.

Verification (ADDR_WIDTH=4, SYNC_STAGES=2)
REQ-027 The bench SHALL drive reset mid-cycle with level=5 and expect empty=1, level=0, read_ptr_gray=5'b00000 and read_addr=0 immediately.
REQ-028 The bench SHALL drive write_ptr_gray 0 -> 5'b00010 (3) and expect empty=1 on the next two edges, then empty=0 and level=3 on the third edge.
REQ-029 The bench SHALL then issue 3 consecutive reads and expect read_addr 1,2,3, read_ptr_gray 00001,00011,00010, level 2,1,0, and empty=1 on the third accepting edge.
REQ-030 The bench SHALL issue read_enable with empty=1 and expect read_addr unchanged and underflow=1 for exactly one cycle.
REQ-031 The bench SHALL drive write_ptr_gray=5'b11000 (16) with rbin=0 and expect level=16; after 16 reads it SHALL expect read_addr=0, read_ptr_gray=5'b11000 and empty=1; it SHALL continue through pointer 31 -> 0 wrap with level correct.
REQ-032 The bench SHALL advance the write pointer by 1 in the same cycle as an accepted read at level=4 and expect level to remain 4.
